palette_loader: RTL and testbench

- Runtime-writable 256x24 palette RAM with a byte-stream loader, the write-side counterpart of the fixed palette lookup.
- A host byte stream (e.g. from the UART command path) carries framed palette updates. The block parses the frames and writes RGB888 entries into the RAM.
- The pixel pipeline reads iter8 -> RGB888 through a 1-cycle registered read port.
- The block sits between the command byte source and the video colour stage.

---
 rtl/palette_pkg.sv | 31 +++
 rtl/palette_ram_dp.sv | 41 ++++
 rtl/palette_loader.sv | 150 +++++++++++++++
 tb/tb_palette_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette loader and its RAM.
package palette_pkg;

    typedef logic [23:0] rgb888_t;
    typedef logic [7:0]  palette_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDX,
        ST_CNT,
        ST_RED,
        ST_GRN,
        ST_BLU,
        ST_COMMIT
    } loader_state_t;

    // Colour triplet assembled from the byte stream before it is committed.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_hold_t;

    localparam int          PAL_DEPTH    = 256;
    localparam logic [7:0]  HDR_BYTE_DEF = 8'h50;

    function automatic rgb888_t gray_entry(input palette_idx_t i);
        return {i, i, i};
    endfunction

endpackage

// File: rtl/palette_ram_dp.sv
// Simple dual-port 256x24 palette RAM: one write port, one registered
// read-first read port. Contents are preloaded (gray ramp or zero) and never reset.
module palette_ram_dp
    import palette_pkg::*;
#(
    parameter bit INIT_GRAY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  palette_idx_t waddr,
    input  rgb888_t      wdata,
    input  palette_idx_t raddr,
    output rgb888_t      rdata
);

    rgb888_t mem [PAL_DEPTH];

    // Power-up contents only; the array is deliberately outside the reset domain.
    initial begin
        for (int i = 0; i < PAL_DEPTH; i++) begin
            mem[i] = INIT_GRAY ? gray_entry(palette_idx_t'(i)) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read alongside the write gives read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/palette_loader.sv
// Byte-stream palette loader: parses HDR/START/COUNT/(R,G,B)* frames into the
// palette RAM. Define PALETTE_SHADOW_EN for a double-buffered, vsync-swapped palette.
module palette_loader
    import palette_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF,
    parameter bit         INIT_GRAY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  palette_idx_t pix_addr,
    output rgb888_t      pix_rgb,
    input  logic         frame_sync,
    output logic         load_busy,
    output logic         load_done,
    output logic         hdr_err
);

    loader_state_t state, state_nxt;
    palette_idx_t  wp;
    logic [8:0]    remaining;
    rgb_hold_t     hold;
    logic          ready_en;
    logic          accept;
    logic          commit;
    logic          last_entry;

    assign in_ready   = ready_en && (state != ST_COMMIT);
    assign accept     = in_valid && in_ready;
    assign commit     = (state == ST_COMMIT);
    assign last_entry = (remaining == 9'd1);
    assign load_busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (accept && in_data == HDR_BYTE) state_nxt = ST_IDX;
            ST_IDX:    if (accept) state_nxt = ST_CNT;
            ST_CNT:    if (accept) state_nxt = ST_RED;
            ST_RED:    if (accept) state_nxt = ST_GRN;
            ST_GRN:    if (accept) state_nxt = ST_BLU;
            ST_BLU:    if (accept) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = last_entry ? ST_IDLE : ST_RED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ready_en holds in_ready low for as long as reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            wp        <= '0;
            remaining <= '0;
            hold      <= '0;
            load_done <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            load_done <= commit && last_entry;
            hdr_err   <= (state == ST_IDLE) && accept && (in_data != HDR_BYTE);
            if (accept) begin
                case (state)
                    ST_IDX: wp        <= in_data;
                    ST_CNT: remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    ST_RED: hold.r    <= in_data;
                    ST_GRN: hold.g    <= in_data;
                    ST_BLU: hold.b    <= in_data;
                    default: ;
                endcase
            end
            if (commit) begin
                wp        <= wp + 8'd1;
                remaining <= remaining - 9'd1;
            end
        end
    end

`ifdef PALETTE_SHADOW_EN
    logic    front;
    logic    front_rd;
    logic    swap_pending;
    rgb888_t rd0, rd1;

    // A swap only honours a pending flag that was already set before this
    // frame_sync, so a load_done coinciding with frame_sync waits one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front        <= 1'b0;
            front_rd     <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            front_rd <= front;
            if (frame_sync && swap_pending) begin
                front        <= ~front;
                swap_pending <= load_done;
            end else if (load_done) begin
                swap_pending <= 1'b1;
            end
        end
    end

    palette_ram_dp #(.INIT_GRAY(INIT_GRAY)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit && front),
        .waddr (wp),
        .wdata (hold),
        .raddr (pix_addr),
        .rdata (rd0)
    );

    palette_ram_dp #(.INIT_GRAY(INIT_GRAY)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit && !front),
        .waddr (wp),
        .wdata (hold),
        .raddr (pix_addr),
        .rdata (rd1)
    );

    // Select with the bank that was front when the read was issued.
    assign pix_rgb = front_rd ? rd1 : rd0;
`else
    logic unused_frame_sync;
    assign unused_frame_sync = frame_sync;

    palette_ram_dp #(.INIT_GRAY(INIT_GRAY)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit),
        .waddr (wp),
        .wdata (hold),
        .raddr (pix_addr),
        .rdata (pix_rgb)
    );
`endif

endmodule

// File: tb/tb_palette_loader.sv
// Self-checking bench for palette_loader: directed frames, table readbacks and
// random frames checked against a per-bank array model of the palette.
module tb_palette_loader;
    import palette_pkg::*;

`ifdef PALETTE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    palette_idx_t pix_addr = '0;
    rgb888_t      pix_rgb;
    logic         frame_sync = 1'b0;
    logic         load_busy, load_done, hdr_err;

    always #5 clk = ~clk;

    palette_loader #(.HDR_BYTE(8'h50), .INIT_GRAY(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pix_addr   (pix_addr),
        .pix_rgb    (pix_rgb),
        .frame_sync (frame_sync),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .hdr_err    (hdr_err)
    );

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Reference palette: bank contents, which bank is displayed, swap pending.
    rgb888_t mb [2][256];
    int      mfront = 0;
    bit      mpend = 1'b0;
    rgb888_t fq [$];

    typedef struct {
        string   name;
        logic [7:0] addr;
        rgb888_t exp;
    } rd_vec_t;
    rd_vec_t tbl [3];

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (hdr_err) err_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic model_write(input int idx, input rgb888_t v);
        mb[SHADOW ? 1 - mfront : 0][idx % 256] = v;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        idle(gap);
        in_data  = b;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends a whole frame using the triplets queued in fq.
    task automatic send_frame(input int start, input int cnt, input int maxgap);
        send_byte(8'h50, $urandom_range(0, maxgap));
        send_byte(8'(start), $urandom_range(0, maxgap));
        send_byte(8'(cnt), $urandom_range(0, maxgap));
        for (int k = 0; k < fq.size(); k++) begin
            send_byte(fq[k][23:16], $urandom_range(0, maxgap));
            send_byte(fq[k][15:8], $urandom_range(0, maxgap));
            send_byte(fq[k][7:0], $urandom_range(0, maxgap));
            model_write(start + k, fq[k]);
        end
        idle(2);
        if (SHADOW) mpend = 1'b1;
    endtask

    task automatic fill_fq(input int n);
        fq.delete();
        for (int k = 0; k < n; k++) fq.push_back(24'($urandom));
    endtask

    task automatic sync();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        if (SHADOW && mpend) begin
            mfront = 1 - mfront;
            mpend  = 1'b0;
        end
        idle(1);
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input rgb888_t exp);
        pix_addr = a;
        @(negedge clk);
        check(name, 32'(pix_rgb), 32'(exp));
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < 256; a++) read_chk(name, 8'(a), mb[mfront][a]);
    endtask

    initial begin
        int d0, e0;
        rgb888_t old20, v16;

        for (int a = 0; a < 256; a++) begin
            mb[0][a] = {8'(a), 8'(a), 8'(a)};
            mb[1][a] = {8'(a), 8'(a), 8'(a)};
        end
        tbl[0] = '{"t2_entry5", 8'd5, 24'h123456};
        tbl[1] = '{"t2_entry4", 8'd4, 24'h040404};
        tbl[2] = '{"t2_entry6", 8'd6, 24'h060606};

        // 1: reset state and gray ramp
        idle(2);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_load_busy", 32'(load_busy), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_hdr_err", 32'(hdr_err), 32'd0);
        check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        sweep("t1_gray");

        // 2: single entry, COMMIT bubble, load_done timing
        send_byte(8'h50, 0);
        check("t2_busy", 32'(load_busy), 32'd1);
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        check("t2_commit_ready", 32'(in_ready), 32'd0);
        check("t2_commit_done", 32'(load_done), 32'd0);
        @(negedge clk);
        check("t2_done_pulse", 32'(load_done), 32'd1);
        check("t2_ready_back", 32'(in_ready), 32'd1);
        check("t2_idle", 32'(load_busy), 32'd0);
        @(negedge clk);
        check("t2_done_clear", 32'(load_done), 32'd0);
        model_write(5, 24'h123456);
        if (SHADOW) mpend = 1'b1;
        sync();
        for (int i = 0; i < 3; i++) read_chk(tbl[i].name, tbl[i].addr, tbl[i].exp);

        // 3: wrap from 250 through 255 to 3
        fill_fq(10);
        d0 = done_cnt;
        send_frame(250, 10, 1);
        idle(2);
        check("t3_done_once", 32'(done_cnt - d0), 32'd1);
        sync();
        sweep("t3_wrap");

        // 4: bad header, then a full 256-entry frame
        e0 = err_cnt;
        send_byte(8'h41, 0);
        idle(3);
        check("t4_hdr_err_once", 32'(err_cnt - e0), 32'd1);
        check("t4_stay_idle", 32'(load_busy), 32'd0);
        fill_fq(256);
        d0 = done_cnt;
        send_frame(0, 0, 0);
        idle(2);
        check("t4_done_once", 32'(done_cnt - d0), 32'd1);
        sync();
        sweep("t4_full");

        // 5: reset after the G byte of the second triplet
        d0 = done_cnt;
        v16 = 24'hA1B2C3;
        send_byte(8'h50, 0);
        send_byte(8'h10, 0);
        send_byte(8'h03, 0);
        send_byte(v16[23:16], 0);
        send_byte(v16[15:8], 0);
        send_byte(v16[7:0], 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        model_write(16, v16);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(in_ready), 32'd0);
        check("t5_rst_busy", 32'(load_busy), 32'd0);
        idle(2);
        rst_n  = 1'b1;
        mfront = 0;
        mpend  = 1'b0;
        idle(3);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        sweep("t5_partial");

        // read-first: read the address being committed in the same cycle
        pix_addr = 8'h20;
        old20 = mb[mfront][8'h20];
        send_byte(8'h50, 0);
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        @(negedge clk);
        check("rf_same_cycle_old", 32'(pix_rgb), 32'(old20));
        model_write(8'h20, 24'hAABBCC);
        if (SHADOW) mpend = 1'b1;
        @(negedge clk);
        check("rf_next_read", 32'(pix_rgb), 32'(mb[mfront][8'h20]));
        idle(1);
        sync();
        read_chk("rf_after_sync", 8'h20, mb[mfront][8'h20]);

        // random frames with random stream gaps
        for (int it = 0; it < 8; it++) begin
            fill_fq($urandom_range(1, 6));
            send_frame($urandom_range(0, 255), fq.size(), 2);
            sync();
        end
        sweep("rand_frames");

`ifdef PALETTE_SHADOW_EN
        // 6: shadow bank swaps only on frame_sync; coincident sync defers it
        fq.delete();
        fq.push_back(24'hFF0000);
        send_frame(0, 1, 0);
        read_chk("t6_before_sync", 8'd0, mb[mfront][0]);
        sync();
        read_chk("t6_after_sync", 8'd0, 24'hFF0000);
        send_byte(8'h50, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h00, 0);
        model_write(1, 24'h00FF00);
        @(negedge clk);
        check("t6_done_coincide", 32'(load_done), 32'd1);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        mpend = 1'b1;
        idle(1);
        read_chk("t6_deferred", 8'd1, mb[mfront][1]);
        sync();
        read_chk("t6_swapped", 8'd1, 24'h00FF00);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
